// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// The mode constants name the meaning of the broadcast input.
// sel_width() derives the select width from the channel count.
package demux_pkg;

    // Meaning of the in_bcast input
    localparam logic MODE_ROUTE = 1'b0;
    localparam logic MODE_BCAST = 1'b1;

    // Select width for n channels; never narrower than one bit
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_ch_buf.sv
// Single-entry output buffer for one demux channel.
// It holds one beat until the consumer takes it.
// Data reads as zero whenever the entry is empty.
// A load and a drain in the same cycle keep the entry full, so one beat per cycle can flow through.
module demux_ch_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // The entry can take a new beat if it is empty or is being drained this cycle
    assign free      = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Load has priority over drain; a drain with no load empties the entry and zeroes its data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= data_in;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-NUM_CH demultiplexer for valid/ready streams.
// Each channel has a one-beat buffer.
// Broadcast beats load every channel at once, and only when all of them are free.
// Beats whose select names a channel that does not exist are accepted and dropped.
// Each dropped beat raises a one-cycle pulse and increments a saturating counter.
module demux_stream_n
    import demux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_width(NUM_CH),
    parameter int ERR_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic                    err_pulse,
    output logic [ERR_W-1:0]        err_cnt
);

    logic [NUM_CH-1:0] w_selOneHot;
    logic [NUM_CH-1:0] w_free;
    logic [NUM_CH-1:0] w_load;
    logic              w_legal;
    logic              w_inReady;
    logic              w_accept;
    logic              w_illegalAccept;

    logic              r_errPulse;
    logic [ERR_W-1:0]  r_errCnt;

    // Select decode and per-channel buffers.
    // A select of NUM_CH or more matches no channel, so the one-hot vector stays all zero.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_selOneHot[k] = (in_sel == SEL_W'(k));
        assign w_load[k]      = w_accept && ((in_bcast == MODE_BCAST) || w_selOneHot[k]);

        demux_ch_buf #(
            .WIDTH(WIDTH)
        ) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (w_load[k]),
            .data_in  (in_data),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[k*WIDTH +: WIDTH]),
            .free     (w_free[k])
        );
    end

    assign w_legal = |w_selOneHot;

    // Input ready depends only on channel state and the select/broadcast inputs, never on in_valid.
    // Illegal selects are always ready so that they can be drained and counted.
    always_comb begin
        w_inReady = 1'b0;
        if (in_bcast == MODE_BCAST) begin
            w_inReady = &w_free;
        end else if (w_legal) begin
            w_inReady = |(w_free & w_selOneHot);
        end else begin
            w_inReady = 1'b1;
        end
    end

    assign in_ready        = w_inReady;
    assign w_accept        = in_valid && w_inReady;
    assign w_illegalAccept = w_accept && (in_bcast == MODE_ROUTE) && !w_legal;

    // Error reporting: pulse the cycle after an illegal beat is dropped; the count holds at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errPulse <= 1'b0;
            r_errCnt   <= '0;
        end else begin
            r_errPulse <= w_illegalAccept;
            if (w_illegalAccept && (r_errCnt != '1)) begin
                r_errCnt <= r_errCnt + ERR_W'(1);
            end
        end
    end

    assign err_pulse = r_errPulse;
    assign err_cnt   = r_errCnt;

endmodule
